// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - memory-stage inputs and register-file write port of the writeback stage
interface writeback_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADR_WIDTH  = 5
);
  logic                  m_valid;
  logic                  m_regwrite;
  logic [ADR_WIDTH-1:0]  m_rd;
  logic [1:0]            m_resultsrc;
  logic [2:0]            m_funct3;
  logic [DATA_WIDTH-1:0] m_alu_result;
  logic [DATA_WIDTH-1:0] m_read_data;
  logic [DATA_WIDTH-1:0] m_pcplus4;

  logic                  we3;
  logic [ADR_WIDTH-1:0]  a3;
  logic [DATA_WIDTH-1:0] wd3;
  logic                  w_valid;
  logic [31:0]           instret;

  modport master (
    output m_valid, m_regwrite, m_rd, m_resultsrc, m_funct3,
           m_alu_result, m_read_data, m_pcplus4,
    input  we3, a3, wd3, w_valid, instret
  );

  modport slave (
    input  m_valid, m_regwrite, m_rd, m_resultsrc, m_funct3,
           m_alu_result, m_read_data, m_pcplus4,
    output we3, a3, wd3, w_valid, instret
  );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - pipeline writeback register, load formatting and retired-instruction counter
module writeback_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADR_WIDTH  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  writeback_stage_if.slave   bus
);

  logic                  valid_q, valid_d;
  logic                  regwrite_q, regwrite_d;
  logic [ADR_WIDTH-1:0]  rd_q, rd_d;
  logic [1:0]            resultsrc_q, resultsrc_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] alu_q, alu_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] pcplus4_q, pcplus4_d;
  logic [31:0]           instret_q, instret_d;

  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] result;

  // Flush only kills valid; the remaining fields keep their last value.
  always_comb begin
    valid_d     = valid_q;
    regwrite_d  = regwrite_q;
    rd_d        = rd_q;
    resultsrc_d = resultsrc_q;
    funct3_d    = funct3_q;
    alu_d       = alu_q;
    rdata_d     = rdata_q;
    pcplus4_d   = pcplus4_q;
    instret_d   = instret_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d     = bus.m_valid;
      regwrite_d  = bus.m_regwrite;
      rd_d        = bus.m_rd;
      resultsrc_d = bus.m_resultsrc;
      funct3_d    = bus.m_funct3;
      alu_d       = bus.m_alu_result;
      rdata_d     = bus.m_read_data;
      pcplus4_d   = bus.m_pcplus4;
      if (bus.m_valid) begin
        instret_d = instret_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      rd_q        <= '0;
      resultsrc_q <= 2'b00;
      funct3_q    <= 3'b000;
      alu_q       <= '0;
      rdata_q     <= '0;
      pcplus4_q   <= '0;
      instret_q   <= 32'd0;
    end else begin
      valid_q     <= valid_d;
      regwrite_q  <= regwrite_d;
      rd_q        <= rd_d;
      resultsrc_q <= resultsrc_d;
      funct3_q    <= funct3_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
      pcplus4_q   <= pcplus4_d;
      instret_q   <= instret_d;
    end
  end

  // Halfword selection uses only address bit 1; misaligned bit 0 is ignored.
  always_comb begin
    byte_sel  = rdata_q[7:0];
    half_sel  = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_data = rdata_q;
    case (alu_q[1:0])
      2'd0:    byte_sel = rdata_q[7:0];
      2'd1:    byte_sel = rdata_q[15:8];
      2'd2:    byte_sel = rdata_q[23:16];
      default: byte_sel = rdata_q[31:24];
    endcase
    case (funct3_q)
      3'b000:  load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      3'b001:  load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    result = alu_q;
    case (resultsrc_q)
      2'b01:   result = load_data;
      2'b10:   result = pcplus4_q;
      default: result = alu_q;
    endcase
  end

  // A stalled valid instruction keeps writing the same value every cycle.
  assign bus.we3     = valid_q & regwrite_q & (rd_q != '0);
  assign bus.a3      = rd_q;
  assign bus.wd3     = result;
  assign bus.w_valid = valid_q;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - randomized bench for writeback_stage with a behavioural reference model
module tb_writeback_stage;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;

  writeback_stage_if bus ();

  writeback_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the instruction currently held by the stage plus a retire counter.
  logic        mv, mrw;
  logic [4:0]  mrd;
  logic [1:0]  msrc;
  logic [2:0]  mf3;
  logic [31:0] malu, mdata, mpc, minstret;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] data,
                                           input logic [31:0] addr);
    logic [31:0] off;
    logic [31:0] b, h;
    off = addr & 32'd3;
    b   = (data >> (8 * off)) & 32'hFF;
    h   = (data >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd3();
    if (msrc == 2'd1) return fmt_load(mf3, mdata, malu);
    if (msrc == 2'd2) return mpc;
    return malu;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mv = 0; mrw = 0; mrd = 0; msrc = 0; mf3 = 0;
    malu = 0; mdata = 0; mpc = 0; minstret = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (flush) begin
      mv = 1'b0;
    end else if (!stall) begin
      mv = bus.m_valid; mrw = bus.m_regwrite; mrd = bus.m_rd;
      msrc = bus.m_resultsrc; mf3 = bus.m_funct3;
      malu = bus.m_alu_result; mdata = bus.m_read_data; mpc = bus.m_pcplus4;
      if (bus.m_valid) minstret = minstret + 32'd1;
    end
  endtask

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_we3", {31'd0, bus.we3}, {31'd0, mv & mrw & (mrd != 5'd0)});
      chk("cyc_a3", {27'd0, bus.a3}, {27'd0, mrd});
      chk("cyc_wd3", bus.wd3, exp_wd3());
      chk("cyc_w_valid", {31'd0, bus.w_valid}, {31'd0, mv});
      chk("cyc_instret", bus.instret, minstret);
    end
  end

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] src,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] data,
                       input logic [31:0] pc);
    bus.m_valid = v; bus.m_regwrite = rw; bus.m_rd = rd; bus.m_resultsrc = src;
    bus.m_funct3 = f3; bus.m_alu_result = alu; bus.m_read_data = data; bus.m_pcplus4 = pc;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic drive_random();
    logic [31:0] r;
    r = $urandom;
    drive(r[0], r[1], r[6:2], r[8:7], r[11:9], $urandom, $urandom, $urandom);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_we3"}, {31'd0, bus.we3}, 32'd0);
    chk({tag, "_a3"}, {27'd0, bus.a3}, 32'd0);
    chk({tag, "_wd3"}, bus.wd3, 32'd0);
    chk({tag, "_w_valid"}, {31'd0, bus.w_valid}, 32'd0);
    chk({tag, "_instret"}, bus.instret, 32'd0);
  endtask

  logic [2:0]  ld_f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [31:0] ld_off [5] = '{32'd3, 32'd1, 32'd2, 32'd0, 32'd0};
  logic [31:0] ld_exp [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_outputs_zero("reset");
    cmp_en = 1'b1;
    #11;
    rst_n = 1'b1;

    drive(1, 1, 5'd5, 2'b00, 3'd0, 32'h1234_5678, 32'd0, 32'd0);
    step();
    chk("alu_we3", {31'd0, bus.we3}, 32'd1);
    chk("alu_a3", {27'd0, bus.a3}, 32'd5);
    chk("alu_wd3", bus.wd3, 32'h1234_5678);
    chk("alu_instret", bus.instret, 32'd1);

    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 5'd3, 2'b01, ld_f3[i], 32'h0000_1000 + ld_off[i], 32'h80FF_7F01, 32'd0);
      step();
      chk($sformatf("load%0d_wd3", i), bus.wd3, ld_exp[i]);
    end

    drive(1, 1, 5'd0, 2'b00, 3'd0, 32'hDEAD_BEEF, 32'd0, 32'd0);
    step();
    chk("x0_we3", {31'd0, bus.we3}, 32'd0);
    drive(1, 1, 5'd1, 2'b10, 3'd0, 32'hDEAD_BEEF, 32'd0, 32'h104);
    step();
    chk("pc4_wd3", bus.wd3, 32'h104);
    chk("pc4_we3", {31'd0, bus.we3}, 32'd1);

    drive(1, 1, 5'd7, 2'b00, 3'd0, 32'h7777, 32'd0, 32'd0);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'(i + 10), 2'b00, 3'd0, 32'(i), 32'd0, 32'd0);
      step();
      chk("stall_a3", {27'd0, bus.a3}, 32'd7);
      chk("stall_we3", {31'd0, bus.we3}, 32'd1);
      chk("stall_instret", bus.instret, 32'd9);
    end
    flush = 1'b1;
    step();
    chk("flush_w_valid", {31'd0, bus.w_valid}, 32'd0);
    chk("flush_we3", {31'd0, bus.we3}, 32'd0);
    chk("flush_instret", bus.instret, 32'd9);
    flush = 1'b0;
    stall = 1'b0;

    for (int i = 0; i < 400; i++) begin
      drive_random();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      step();
    end
    flush = 1'b0;

    // Preload the retire counter near wrap while stalled so the flop keeps the value.
    stall = 1'b1;
    force dut.instret_q = 32'hFFFF_FFFF;
    minstret = 32'hFFFF_FFFF;
    step();
    release dut.instret_q;
    chk("preload_instret", bus.instret, 32'hFFFF_FFFF);
    stall = 1'b0;
    drive(1, 1, 5'd4, 2'b00, 3'd0, 32'h55, 32'd0, 32'd0);
    step();
    chk("wrap_instret", bus.instret, 32'd0);

    stall = 1'b1;
    force dut.instret_q = 32'hFFFF_FFFF;
    minstret = 32'hFFFF_FFFF;
    step();
    release dut.instret_q;
    flush = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs_zero("async_rst");
    step();
    check_outputs_zero("rst_held");
    rst_n = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1, 1, 5'd9, 2'b00, 3'd0, 32'hABCD, 32'd0, 32'd0);
    step();
    chk("post_rst_instret", bus.instret, 32'd1);
    chk("post_rst_a3", {27'd0, bus.a3}, 32'd9);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter: DATA_WIDTH, 32, datapath width.
REQ-002 Parameter: ADR_WIDTH, 5, register address width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 stall  input  1  hold stage contents.
REQ-007 flush  input  1  insert bubble.
REQ-008 m_valid  input  1  memory-stage instruction valid.
REQ-009 m_regwrite  input  1  instruction writes rd.
REQ-010 m_rd  input  ADR_WIDTH  destination register.
REQ-011 m_resultsrc  input  2  00 ALU, 01 load, 10 PC+4, 11 ALU.
REQ-012 m_funct3  input  3  load type.
REQ-013 m_alu_result  input  DATA_WIDTH  ALU result / load address.
REQ-014 m_read_data  input  DATA_WIDTH  aligned memory word.
REQ-015 m_pcplus4  input  DATA_WIDTH  PC+4.
REQ-016 we3  output  1  register-file write enable.
REQ-017 a3  output  ADR_WIDTH  register-file write address.
REQ-018 wd3  output  DATA_WIDTH  register-file write data (also forwarding value).
REQ-019 w_valid  output  1  stage holds valid instruction.
REQ-020 instret  output  32  retired-instruction count.

Function
REQ-021 The stage SHALL register all m_* inputs on the rising edge; one-cycle latency from input to output.
REQ-022 Edge priority SHALL be: flush (valid<=0, other fields don't-care but held), else stall (all registers hold), else capture.
REQ-023 we3 SHALL equal w_valid AND registered regwrite AND (a3 != 0).
REQ-024 a3 SHALL equal the registered rd unconditionally.
REQ-025 wd3 SHALL be combinational from registered fields: resultsrc 00/11 ALU result, 01 formatted load, 10 PC+4.
REQ-026 Load formatting SHALL use off = alu_result[1:0]: 000 LB sign-extend byte[off]; 100 LBU zero-extend byte[off]; 001 LH sign-extend half[off[1]]; 101 LHU zero-extend half[off[1]]; 010 and 011/110/111 full word.
REQ-027 Byte k SHALL be read_data[8k+7:8k]; half h SHALL be read_data[16h+15:16h]; off[0] SHALL be ignored for halfwords.
REQ-028 instret SHALL increment by 1 on each edge where rst_n=1, flush=0, stall=0, m_valid=1; wrap 0xFFFFFFFF -> 0.
REQ-029 During stall with w_valid=1, we3 SHALL stay asserted and rewrite the same value each cycle; instret SHALL NOT increment.
REQ-030 Flush and stall together SHALL produce a bubble (flush wins); instret unchanged.

Reset
REQ-031 rst_n low SHALL immediately clear all registered fields and instret to 0, independent of clk.
REQ-032 During and after reset until first capture: we3=0, a3=0, wd3=0, w_valid=0, instret=0.
REQ-033 Reset asserted mid-stall or mid-flush SHALL override both; first capture occurs on the first edge with rst_n high.

Verification
REQ-034 ALU write: m_valid=1, regwrite=1, rd=5, resultsrc=00, alu=0x12345678 -> next cycle we3=1, a3=5, wd3=0x12345678, instret=1.
REQ-035 Loads with read_data=0x80FF7F01: LB off=3 -> 0xFFFFFF80; LBU off=1 -> 0x0000007F; LH off=2 -> 0xFFFF80FF; LHU off=0 -> 0x00007F01; LW -> 0x80FF7F01.
REQ-036 x0 and PC+4: rd=0, regwrite=1 -> we3=0; rd=1, resultsrc=10, pcplus4=0x104 -> wd3=0x104, we3=1.
REQ-037 Stall/flush: capture rd=7, stall 3 cycles with new inputs -> a3=7 held, instret unchanged; flush+stall -> w_valid=0, we3=0.
REQ-038 Async reset mid-operation with instret=0xFFFFFFFF: drop rst_n between edges -> outputs 0 immediately; separately, one more valid capture from 0xFFFFFFFF -> instret=0.
